// File: rtl/uart_pkg.sv
// uart_stream: shared FSM types and baud arithmetic
// for the serial front end of the picture-transfer path.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int MIN_CLKS_PER_BIT = 4;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_stream_if.sv
// uart_stream: byte-stream handshake between the UART
// front end and the transfer controller.
interface uart_stream_if;

  logic [7:0] data_stream_rx;
  logic       data_stream_rx_stb;
  logic       rx_frame_err;
  logic [7:0] data_stream_tx;
  logic       data_stream_tx_stb;
  logic       data_stream_tx_ack;

  modport master (
    input  data_stream_rx,
    input  data_stream_rx_stb,
    input  rx_frame_err,
    output data_stream_tx,
    output data_stream_tx_stb,
    input  data_stream_tx_ack
  );

  modport slave (
    output data_stream_rx,
    output data_stream_rx_stb,
    output rx_frame_err,
    input  data_stream_tx,
    input  data_stream_tx_stb,
    output data_stream_tx_ack
  );

endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizer,
// mid-bit sampling and stop-bit framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] data,
  output logic       stb,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]    sync;
  logic          rxd;
  logic          rxd_q;
  logic          fall;
  logic          expire;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rxd    = sync[1];
  assign fall   = rxd_q & ~rxd;
  assign expire = (cnt == '0);

  // Line idles high, so reset to 1 avoids a false start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      rxd_q <= 1'b1;
    end else begin
      sync  <= {sync[0], uart_rxd};
      rxd_q <= rxd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      stb       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      stb       <= 1'b0;
      frame_err <= 1'b0;
      if (state != RX_IDLE && !expire)
        cnt <= cnt - ONE;
      unique case (state)
        RX_IDLE: begin
          if (fall) begin
            state <= RX_START;
            cnt   <= HALF;
          end
        end
        RX_START: begin
          if (expire) begin
            if (rxd) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= FULL;
              bit_idx <= '0;
            end
          end
        end
        RX_DATA: begin
          if (expire) begin
            shreg   <= {rxd, shreg[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (expire) begin
            state <= RX_IDLE;
            if (rxd) begin
              data <= shreg;
              stb  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_stream.sv
// uart_stream: UART line <-> byte stream bridge,
// 8N1 at a fixed baud rate, full duplex.
module uart_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rxd,
  output logic          uart_txd,
  uart_stream_if.slave  bus
);

  localparam int CLKS_PER_BIT =
    clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_baud
    $error("uart_stream: CLKS_PER_BIT below 4");
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .data      (bus.data_stream_rx),
    .stb       (bus.data_stream_rx_stb),
    .frame_err (bus.rx_frame_err)
  );

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx_expire;

  assign tx_expire = (tx_cnt == '0);

  // Leaving IDLE on the latch edge makes a held stb
  // impossible to ack twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state               <= TX_IDLE;
      tx_cnt                 <= '0;
      tx_bit                 <= '0;
      tx_shreg               <= '0;
      uart_txd               <= 1'b1;
      bus.data_stream_tx_ack <= 1'b0;
    end else begin
      bus.data_stream_tx_ack <= 1'b0;
      if (tx_state != TX_IDLE && !tx_expire)
        tx_cnt <= tx_cnt - ONE;
      unique case (tx_state)
        TX_IDLE: begin
          uart_txd <= 1'b1;
          if (bus.data_stream_tx_stb) begin
            tx_shreg               <= bus.data_stream_tx;
            bus.data_stream_tx_ack <= 1'b1;
            uart_txd               <= 1'b0;
            tx_cnt                 <= FULL;
            tx_state               <= TX_START;
          end
        end
        TX_START: begin
          if (tx_expire) begin
            uart_txd <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= FULL;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_expire) begin
            tx_cnt <= FULL;
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_txd <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_expire)
            tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream.sv
// tb_uart_stream: directed bench for uart_stream at
// 16 clocks per bit, scoreboarded RX and bit-level TX.
module tb_uart_stream;

  logic clk = 1'b0;
  logic reset;
  logic rxd_drv;
  logic loopback;
  logic rxd_pin;
  logic uart_txd;

  uart_stream_if bus();

  assign rxd_pin = loopback ? uart_txd : rxd_drv;

  uart_stream #(
    .CLK_FREQ_HZ(1_843_200),
    .BAUD       (115200)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (rxd_pin),
    .uart_txd (uart_txd),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int ack_cnt = 0;
  int stb_cyc = 0;
  int rx_start = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.data_stream_rx_stb === 1'b1) begin
      stb_cnt++;
      stb_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rx_unexpected",
              32'(bus.data_stream_rx), 32'h100);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(bus.data_stream_rx), 32'(e));
      end
    end
    if (bus.rx_frame_err === 1'b1) err_cnt++;
    if (bus.data_stream_tx_ack === 1'b1) ack_cnt++;
  end

  task automatic send_rx(input logic [7:0] b,
                         input logic stop,
                         input int tail_low);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    rx_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[4'(i)];
      repeat (16) @(negedge clk);
    end
    repeat (tail_low) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  // Called at the first negedge where the start bit shows.
  task automatic tx_frame_check(input logic [7:0] b,
                                input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 8 : 16) @(negedge clk);
      check(tag, 32'(uart_txd), 32'(f[4'(k)]));
    end
  endtask

  task automatic tx_request(input logic [7:0] b,
                            input string tag);
    int n;
    n = 0;
    bus.data_stream_tx     = b;
    bus.data_stream_tx_stb = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.data_stream_tx_ack !== 1'b1 && n < 400);
    check(tag, 32'(bus.data_stream_tx_ack), 1);
    bus.data_stream_tx_stb = 1'b0;
  endtask

  int s0, e0, a0, lat, gap;
  logic [9:0] frame6;

  initial begin
    reset                  = 1'b1;
    rxd_drv                = 1'b1;
    loopback               = 1'b0;
    bus.data_stream_tx     = '0;
    bus.data_stream_tx_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 1);
    check("rst_rx", 32'(bus.data_stream_rx), 0);
    check("rst_stb", 32'(bus.data_stream_rx_stb), 0);
    check("rst_err", 32'(bus.rx_frame_err), 0);
    check("rst_ack", 32'(bus.data_stream_tx_ack), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // good frame 't'
    s0 = stb_cnt; e0 = err_cnt;
    exp_q.push_back(8'h74);
    send_rx(8'h74, 1'b1, 0);
    lat = stb_cyc - rx_start;
    check("rx74_latency_154pm1",
          32'(lat >= 153 && lat <= 155), 1);
    check("rx74_stb_count", stb_cnt - s0, 1);
    check("rx74_no_err", err_cnt - e0, 0);
    check("rx74_hold", 32'(bus.data_stream_rx), 32'h74);

    // bad stop bit, line left low afterwards
    s0 = stb_cnt; e0 = err_cnt;
    send_rx(8'hA5, 1'b0, 40);
    check("ferr_count", err_cnt - e0, 1);
    check("ferr_no_stb", stb_cnt - s0, 0);
    check("ferr_rx_kept", 32'(bus.data_stream_rx), 32'h74);

    // short glitch then good frame
    s0 = stb_cnt; e0 = err_cnt;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_stb", stb_cnt - s0, 0);
    check("glitch_no_err", err_cnt - e0, 0);
    exp_q.push_back(8'h72);
    send_rx(8'h72, 1'b1, 0);
    check("rx72_stb_count", stb_cnt - s0, 1);
    check("rx72_value", 32'(bus.data_stream_rx), 32'h72);

    // back-to-back TX with stb held high
    a0 = ack_cnt;
    bus.data_stream_tx     = 8'h79;
    bus.data_stream_tx_stb = 1'b1;
    @(negedge clk);
    check("tx_ack1", 32'(bus.data_stream_tx_ack), 1);
    check("tx_start1", 32'(uart_txd), 0);
    bus.data_stream_tx = 8'h3C;
    tx_frame_check(8'h79, "tx_bit_79");
    gap = 0;
    while (uart_txd === 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("tx_next_start_gap", gap, 9);
    check("tx_ack2", 32'(bus.data_stream_tx_ack), 1);
    bus.data_stream_tx_stb = 1'b0;
    tx_frame_check(8'h3C, "tx_bit_3c");
    repeat (40) @(negedge clk);
    check("tx_ack_count", ack_cnt - a0, 2);
    check("tx_idle_high", 32'(uart_txd), 1);

    // loopback full duplex
    loopback = 1'b1;
    s0 = stb_cnt;
    exp_q.push_back(8'h00);
    tx_request(8'h00, "lb_ack_00");
    exp_q.push_back(8'hFF);
    tx_request(8'hFF, "lb_ack_ff");
    exp_q.push_back(8'h55);
    tx_request(8'h55, "lb_ack_55");
    repeat (400) @(negedge clk);
    check("lb_stb_count", stb_cnt - s0, 3);
    check("lb_queue_empty", exp_q.size(), 0);
    check("lb_last", 32'(bus.data_stream_rx), 32'h55);
    loopback = 1'b0;
    repeat (20) @(negedge clk);

    // reset mid TX bit 3 and mid RX bit 5
    frame6 = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      rxd_drv = frame6[4'(c / 16)];
      if (c == 30) begin
        bus.data_stream_tx     = 8'hC3;
        bus.data_stream_tx_stb = 1'b1;
      end
      if (c == 31) bus.data_stream_tx_stb = 1'b0;
    end
    check("pre_rst_tx_bit3", 32'(uart_txd), 0);
    s0 = stb_cnt; e0 = err_cnt; a0 = ack_cnt;
    reset   = 1'b1;
    rxd_drv = 1'b1;
    #1;
    check("mid_rst_txd", 32'(uart_txd), 1);
    check("mid_rst_rx", 32'(bus.data_stream_rx), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("post_rst_txd", 32'(uart_txd), 1);
    check("post_rst_no_stb", stb_cnt - s0, 0);
    check("post_rst_no_err", err_cnt - e0, 0);
    check("post_rst_no_ack", ack_cnt - a0, 0);
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 0);
    check("post_rst_rx_count", stb_cnt - s0, 1);
    tx_request(8'hA6, "post_rst_ack");
    tx_frame_check(8'hA6, "post_rst_tx");
    repeat (20) @(negedge clk);
    check("post_rst_ack_count", ack_cnt - a0, 1);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_count", err_cnt - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_stream.md
# uart_stream

Serial front end of the picture-transfer path. Converts the PC's UART line into the byte-stream interface consumed by the transfer controller:
- received bytes leave as `data_stream_rx` with a one-cycle strobe;
- bytes offered on `data_stream_tx` with a strobe/ack handshake are serialized onto the TX line.

Format is fixed at 8N1, LSB first, with one fixed baud rate set by parameters.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000, system clock frequency.
- `BAUD`, default 115200, line rate.
- Derived: `CLKS_PER_BIT` = `CLK_FREQ_HZ/BAUD`, integer division (868 at the defaults). Elaboration error if it is below 4.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high.
- `uart_rxd`  in  1  serial line from the PC, asynchronous, idles high.
- `uart_txd`  out  1  serial line to the PC, idles high.
- `data_stream_rx`  out  8  last received byte; holds until the next good byte.
- `data_stream_rx_stb`  out  1  one-cycle pulse when `data_stream_rx` is updated.
- `rx_frame_err`  out  1  one-cycle pulse when a frame has a bad stop bit.
- `data_stream_tx`  in  8  byte to send; must be stable while `data_stream_tx_stb` is high.
- `data_stream_tx_stb`  in  1  send request; held high until ack.
- `data_stream_tx_ack`  out  1  one-cycle pulse when the byte has been latched.

## Operation
- **RX input conditioning:** `uart_rxd` passes through a 2-flop synchronizer (reset value 1) before any use.
- **RX FSM**
  - RX_IDLE: a synchronized falling edge goes to RX_START. The bit counter loads `CLKS_PER_BIT/2 - 1`.
  - RX_START: at counter expiry, sample the line.
    - Line still 0 → RX_DATA, counter reloads `CLKS_PER_BIT-1`.
    - Line 1 → glitch, return to RX_IDLE with no output.
  - RX_DATA: sample at each expiry and shift in LSB first. After bit 7 → RX_STOP.
  - RX_STOP: sample at expiry.
    - Stop bit 1 → load `data_stream_rx` and pulse `data_stream_rx_stb`.
    - Stop bit 0 → pulse `rx_frame_err`; `data_stream_rx` is unchanged.
    - Either way, return to RX_IDLE.
  - RX_IDLE only re-arms on a new falling edge, so a line held low after a framing error starts no new frame.
- **TX FSM**
  - TX_IDLE: `uart_txd`=1. If `data_stream_tx_stb`=1, latch `data_stream_tx` into the shift register, register `data_stream_tx_ack`=1 for the next cycle, and go to TX_START.
  - TX_START: drive 0 for `CLKS_PER_BIT` cycles.
  - TX_DATA: drive 8 bits LSB first, `CLKS_PER_BIT` cycles each.
  - TX_STOP: drive 1 for `CLKS_PER_BIT` cycles, then go to TX_IDLE.
  - The ack is never repeated for one request: while the requester still sees stb high in the ack cycle, the TX FSM is already out of TX_IDLE.
- RX and TX are fully independent. Simultaneous receive and transmit is required.
- **Reset, at any time including mid-frame:**
  - Both FSMs go to IDLE and counters clear.
  - `uart_txd`=1; `data_stream_rx_stb`, `rx_frame_err` and `data_stream_tx_ack` are 0; `data_stream_rx`=0.
  - A partially sent TX byte is abandoned, with no ack re-issued.

## Timing
- RX latency: `data_stream_rx_stb` rises 2 (synchronizer) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the start-bit falling edge at the pin, ±1 cycle.
- TX: `data_stream_tx_ack` is high in cycle N+1 for a stb sampled at edge N. The start bit appears on `uart_txd` from cycle N+1.
- TX frame length: exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back TX: with stb held high, the next start bit begins 1 cycle after the stop bit ends (one TX_IDLE cycle).
- All outputs are registered; `uart_txd` is glitch-free.

## Structure
- Package `uart_pkg`: `rx_state_t` and `tx_state_t` enums, plus a function computing `CLKS_PER_BIT`.
- Sub-module `uart_rx` holds the synchronizer, RX FSM and RX counter. The TX FSM sits in `uart_stream` beside the `uart_rx` instance.
- Counter width is `$clog2(CLKS_PER_BIT)`.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1_843_200 and `BAUD`=115200, so `CLKS_PER_BIT`=16.
- Drive frame 0x74 ('t') on `uart_rxd` → single `data_stream_rx_stb` pulse with `data_stream_rx`=0x74, 154±1 cycles after the start edge; `rx_frame_err` stays 0.
- Frame 0xA5 with stop bit forced 0 → one `rx_frame_err` pulse, no stb, `data_stream_rx` keeps its previous value.
- 4-cycle low glitch on `uart_rxd` → no stb and no error; a following valid 0x72 is received correctly.
- Hold stb with bytes 0x79 then 0x3C → exactly one ack each; `uart_txd` shows 0,1,0,0,1,1,1,1,0,1 (16 cycles per bit); the second start bit follows 1 idle cycle later.
- Loop `uart_txd` back to `uart_rxd` and send 0x00, 0xFF, 0x55 → the same three bytes are received in order, with full-duplex traffic overlapping.
- Assert reset mid-TX at bit 3 and mid-RX at bit 5 → `uart_txd`=1 immediately; no stb, ack or error pulses; the next frames work normally.
